softmax_max_buf: RTL and testbench

SOFTMAX_MAX_BUF -- requirements
Module: softmax_max_buf

---
 rtl/softmax_pkg.sv | 15 +
 rtl/maxbuf_rf.sv | 24 ++
 rtl/softmax_max_buf.sv | 126 ++++++++++++
 tb/tb_softmax_max_buf.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared constants and state encoding for the softmax max/replay buffer.
package softmax_pkg;

   localparam int Q88_W = 16;
   localparam int DEF_N = 8;

   localparam logic signed [Q88_W-1:0] Q88_MIN = 16'sh8000;
   localparam logic signed [Q88_W-1:0] Q88_MAX = 16'sh7FFF;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

endpackage

// File: rtl/maxbuf_rf.sv
// N x DATA_W sample store: one synchronous write port, one asynchronous read port.
module maxbuf_rf #(
   parameter int DATA_W = 16,
   parameter int N      = 8,
   parameter int IDX_W  = $clog2(N)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [N];

   // NOTE: storage is deliberately left out of reset; every slot is written before it is read.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/softmax_max_buf.sv
// Buffers a Q8.8 vector, tracks its maximum, then replays samples alongside the max.
// Optional macro SOFTMAX_MAXBUF_PRESUB_EN: out_x becomes saturated x_i - max.
module softmax_max_buf
   import softmax_pkg::*;
#(
   parameter int DATA_W = Q88_W,
   parameter int N      = DEF_N
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     valid_in,
   input  logic signed [DATA_W-1:0] in_x,
   input  logic                     in_last,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] out_max,
   output logic signed [DATA_W-1:0] out_x,
   output logic                     valid_out,
   output logic                     out_last
);

   localparam int IDX_W = $clog2(N);
   localparam int LEN_W = $clog2(N + 1);

   state_t state_q, state_d;
   logic [IDX_W-1:0] cnt_q, rd_q;
   logic [LEN_W-1:0] len_q;
   logic signed [DATA_W-1:0] max_q;
   logic max_vld_q;

   logic accept, close, emit_rd, emit_last;
   logic [DATA_W-1:0] rf_rdata;

   // Read stage sits between the buffer and the output registers.
   logic s1_vld, s1_last;
   logic signed [DATA_W-1:0] s1_x, s1_max;
   logic signed [DATA_W-1:0] x_out_d;

   assign in_ready  = (state_q == ST_LOAD);
   assign accept    = en & valid_in & (state_q == ST_LOAD);
   assign close     = accept & (in_last | (cnt_q == IDX_W'(N - 1)));
   assign emit_rd   = en & (state_q == ST_EMIT);
   assign emit_last = emit_rd & (LEN_W'(rd_q) == len_q - LEN_W'(1));

   maxbuf_rf #(.DATA_W(DATA_W), .N(N), .IDX_W(IDX_W)) u_rf (
      .clk   (clk),
      .we    (accept),
      .waddr (cnt_q),
      .wdata (in_x),
      .raddr (rd_q),
      .rdata (rf_rdata)
   );

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         ST_LOAD: if (close)     state_d = ST_EMIT;
         ST_EMIT: if (emit_last) state_d = ST_LOAD;
         default:                state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)     state_q <= ST_LOAD;
      else if (en) state_q <= state_d;
   end

`ifdef SOFTMAX_MAXBUF_PRESUB_EN
   localparam logic signed [DATA_W:0] MIN_EXT = {2'b11, {(DATA_W-1){1'b0}}};
   logic signed [DATA_W:0] diff;

   always_comb begin
      diff = {s1_x[DATA_W-1], s1_x} - {s1_max[DATA_W-1], s1_max};
      if (diff < MIN_EXT) x_out_d = MIN_EXT[DATA_W-1:0];
      else                x_out_d = diff[DATA_W-1:0];
   end
`else
   assign x_out_d = s1_x;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: non-blocking everywhere in clocked logic so all registers update from pre-edge values.
         cnt_q     <= '0;
         rd_q      <= '0;
         len_q     <= '0;
         max_q     <= '0;
         max_vld_q <= 1'b0;
         s1_vld    <= 1'b0;
         s1_last   <= 1'b0;
         s1_x      <= '0;
         s1_max    <= '0;
         valid_out <= 1'b0;
         out_last  <= 1'b0;
         out_x     <= '0;
         out_max   <= '0;
      end else if (en) begin
         if (accept) begin
            cnt_q     <= close ? '0 : cnt_q + IDX_W'(1);
            max_vld_q <= 1'b1;
            if (!max_vld_q || in_x > max_q) max_q <= in_x;
            if (close) len_q <= LEN_W'(cnt_q) + LEN_W'(1);
         end
         if (emit_rd) begin
            rd_q   <= emit_last ? '0 : rd_q + IDX_W'(1);
            s1_x   <= rf_rdata;
            s1_max <= max_q;
            if (emit_last) max_vld_q <= 1'b0;
         end
         s1_vld    <= emit_rd;
         s1_last   <= emit_last;
         valid_out <= s1_vld;
         out_last  <= s1_last;
         if (s1_vld) begin
            out_x   <= x_out_d;
            out_max <= s1_max;
         end
      end else begin
         // Stalled cycles present no output; data registers keep their last value.
         valid_out <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_softmax_max_buf.sv
// Scoreboard bench for softmax_max_buf: vector-level reference model plus output monitor.
module tb_softmax_max_buf;

   localparam int DW = 16;
   localparam int N  = 8;

   logic clk = 1'b0;
   logic rst, en, valid_in, in_last;
   logic [DW-1:0] in_x;
   logic in_ready, valid_out, out_last;
   logic [DW-1:0] out_max, out_x;

   softmax_max_buf #(.DATA_W(DW), .N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .valid_in  (valid_in),
      .in_x      (in_x),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_max   (out_max),
      .out_x     (out_x),
      .valid_out (valid_out),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] x;
      logic [DW-1:0] mx;
      logic          last;
   } exp_t;

   exp_t sb[$];
   int   cur[$];
   int   busy = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   started = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] ref_x(input int x, input int mx);
`ifdef SOFTMAX_MAXBUF_PRESUB_EN
      int d;
      d = x - mx;
      if (d < -32768) d = -32768;
      return DW'(d);
`else
      return DW'(x);
`endif
   endfunction

   task automatic close_vec();
      int mx;
      exp_t e;
      mx = cur[0];
      foreach (cur[i]) if (cur[i] > mx) mx = cur[i];
      foreach (cur[i]) begin
         e.x    = ref_x(cur[i], mx);
         e.mx   = DW'(mx);
         e.last = (i == cur.size() - 1);
         sb.push_back(e);
      end
      busy = cur.size();
      cur.delete();
   endtask

   // Drive one clock of stimulus; the model decides acceptance from its own busy count.
   task automatic cycle(input logic e, input logic v, input logic l, input logic [DW-1:0] x);
      int xi;
      en = e; valid_in = v; in_last = l; in_x = x;
      check("in_ready", {31'd0, in_ready}, {31'd0, busy == 0});
      if (e && v && busy == 0) begin
         xi = $signed(x);
         cur.push_back(xi);
         if (l || cur.size() == N) close_vec();
      end else if (e && busy > 0) begin
         busy--;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input logic e);
      rst = 1'b1; en = e; valid_in = 1'b0; in_last = 1'b0; in_x = '0;
      @(posedge clk);
      sb.delete();
      cur.delete();
      busy = 0;
      #1;
      rst = 1'b0;
      check("rst_valid_out", {31'd0, valid_out}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_x", {16'd0, out_x}, 32'd0);
      check("rst_out_max", {16'd0, out_max}, 32'd0);
   endtask

   // Monitor: compares DUT outputs against the scoreboard, and checks hold behaviour on stalls.
   logic en_prev = 1'b1, rst_prev = 1'b1;
   logic [DW-1:0] hold_x = '0, hold_max = '0;
   always @(posedge clk) begin
      en_prev  <= en;
      rst_prev <= rst;
   end

   always @(negedge clk) begin
      exp_t e;
      if (started) begin
         if (!en_prev && !rst_prev) begin
            check("stall_valid_out", {31'd0, valid_out}, 32'd0);
            check("stall_out_x", {16'd0, out_x}, {16'd0, hold_x});
            check("stall_out_max", {16'd0, out_max}, {16'd0, hold_max});
         end
         if (valid_out) begin
            if (sb.size() == 0) begin
               check("unexpected_out", {31'd0, valid_out}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("out_x", {16'd0, out_x}, {16'd0, e.x});
               check("out_max", {16'd0, out_max}, {16'd0, e.mx});
               check("out_last", {31'd0, out_last}, {31'd0, e.last});
            end
         end else begin
            check("idle_out_last", {31'd0, out_last}, 32'd0);
         end
         hold_x   = out_x;
         hold_max = out_max;
      end
   end

   task automatic drain();
      repeat (2 * N + 4) cycle(1'b1, 1'b0, 1'b0, '0);
      check("sb_empty", sb.size(), 32'd0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; valid_in = 1'b0; in_last = 1'b0; in_x = '0;
      do_reset(1'b1);
      started = 1'b1;

      // Two-sample vector with explicit latency measurement.
      cycle(1'b1, 1'b1, 1'b0, 16'h0100);
      cycle(1'b1, 1'b1, 1'b1, 16'h0240);
      check("lat_edge0", {31'd0, valid_out}, 32'd0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      check("lat_edge1", {31'd0, valid_out}, 32'd0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      check("lat_edge2", {31'd0, valid_out}, 32'd1);
      drain();

      // All-negative vector.
      cycle(1'b1, 1'b1, 1'b0, 16'hFF00);
      cycle(1'b1, 1'b1, 1'b0, 16'hFE00);
      cycle(1'b1, 1'b1, 1'b1, 16'hFF80);
      drain();

      // Single-sample vector.
      cycle(1'b1, 1'b1, 1'b1, 16'h0333);
      drain();

      // Auto-close at N samples, then valid_in held high during replay.
      for (int i = 0; i < N; i++) cycle(1'b1, 1'b1, 1'b0, 16'($urandom));
      for (int i = 0; i < N; i++) cycle(1'b1, 1'b1, 1'b0, 16'($urandom));
      drain();

      // Enable dropped for three cycles mid-replay.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, i == 3, 16'($urandom));
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 16'($urandom));
      drain();

      // Reset mid-replay discards the rest of the vector.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, i == 4, 16'($urandom));
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      do_reset(1'b0);
      drain();

      // Saturation corner for the pre-subtract build; plain replay otherwise.
      cycle(1'b1, 1'b1, 1'b0, 16'h8000);
      cycle(1'b1, 1'b1, 1'b1, 16'h7F00);
      drain();

      // Randomised traffic with stalls, gaps and the occasional reset.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset(1'($urandom));
         else cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 4) == 0), 16'($urandom));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
